// File: rtl/tnoc_axi_pkg.sv
// tnoc_axi_pkg: shared AXI configuration, burst encodings and length/size helpers.
package tnoc_axi_pkg;

   typedef struct packed {
      int id_width;
      int address_width;
      int data_width;
   } tnoc_axi_config;

   localparam tnoc_axi_config TNOC_DEFAULT_AXI_CONFIG = '{
      id_width:      4,
      address_width: 32,
      data_width:    64
   };

   typedef logic [7:0] tnoc_axi_burst_length;
   typedef logic [7:0] tnoc_axi_beat_index;

   typedef enum logic [2:0] {
      TNOC_AXI_BURST_SIZE_1_BYTE,
      TNOC_AXI_BURST_SIZE_2_BYTES,
      TNOC_AXI_BURST_SIZE_4_BYTES,
      TNOC_AXI_BURST_SIZE_8_BYTES,
      TNOC_AXI_BURST_SIZE_16_BYTES,
      TNOC_AXI_BURST_SIZE_32_BYTES,
      TNOC_AXI_BURST_SIZE_64_BYTES,
      TNOC_AXI_BURST_SIZE_128_BYTES
   } tnoc_axi_burst_size;

   typedef enum logic [1:0] {
      TNOC_AXI_FIXED_BURST,
      TNOC_AXI_INCREMENTING_BURST,
      TNOC_AXI_WRAPPING_BURST,
      TNOC_AXI_RESERVED_BURST
   } tnoc_axi_burst_type;

   typedef enum logic {
      TNOC_AXI_BURST_IDLE,
      TNOC_AXI_BURST_ACTIVE
   } tnoc_axi_burst_state;

   function automatic logic [8:0] unpack_burst_length(tnoc_axi_burst_length length);
      return {1'b0, length} + 9'd1;
   endfunction

   function automatic tnoc_axi_burst_length pack_burst_length(logic [8:0] beats);
      return 8'(beats - 9'd1);
   endfunction

   function automatic logic [7:0] get_burst_size_in_bytes(tnoc_axi_burst_size size);
      return 8'd1 << size;
   endfunction

   function automatic logic is_valid_wrap_length(tnoc_axi_burst_length length);
      return length inside {8'd1, 8'd3, 8'd7, 8'd15};
   endfunction

endpackage

// File: rtl/tnoc_axi_next_address_calc.sv
// tnoc_axi_next_address_calc: combinational next-beat address for FIXED/INCR/WRAP bursts.
module tnoc_axi_next_address_calc
   import tnoc_axi_pkg::*;
#(
   parameter int AW = 32
)(
   input  tnoc_axi_burst_type i_burst_type,
   input  tnoc_axi_burst_size i_burst_size,
   input  logic [AW-1:0]      i_address,
   input  logic [AW-1:0]      i_base,
   input  logic [AW-1:0]      i_span,
   output logic [AW-1:0]      o_next_address
);

   logic [AW-1:0] bytes;
   logic [AW-1:0] aligned;
   logic [AW-1:0] incr;

   always_comb begin
      bytes          = AW'(get_burst_size_in_bytes(i_burst_size));
      aligned        = i_address & ~(bytes - AW'(1));
      incr           = aligned + bytes;
      o_next_address = (i_burst_type == TNOC_AXI_FIXED_BURST) ? i_address :
                       (i_burst_type == TNOC_AXI_WRAPPING_BURST && incr == i_base + i_span) ? i_base : incr;
   end

endmodule

// File: rtl/tnoc_axi_burst_address_generator.sv
// tnoc_axi_burst_address_generator: expands one AXI AW/AR command into per-beat addresses.
// Define TNOC_AXI_BURST_ADDRESS_BACK_TO_BACK_EN to accept the next command on the last beat handshake.
module tnoc_axi_burst_address_generator
   import tnoc_axi_pkg::*;
#(
   parameter tnoc_axi_config AXI_CONFIG = TNOC_DEFAULT_AXI_CONFIG
)(
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  logic                                i_command_valid,
   output logic                                o_command_ready,
   input  logic [AXI_CONFIG.id_width-1:0]      i_id,
   input  logic [AXI_CONFIG.address_width-1:0] i_address,
   input  logic [7:0]                          i_burst_length,
   input  logic [2:0]                          i_burst_size,
   input  logic [1:0]                          i_burst_type,
   output logic                                o_beat_valid,
   input  logic                                i_beat_ready,
   output logic [AXI_CONFIG.id_width-1:0]      o_beat_id,
   output logic [AXI_CONFIG.address_width-1:0] o_beat_address,
   output logic [7:0]                          o_beat_index,
   output logic                                o_beat_last,
   output logic                                o_beat_error
);

   localparam int IW = AXI_CONFIG.id_width;
   localparam int AW = AXI_CONFIG.address_width;
   localparam int DW = AXI_CONFIG.data_width;

   tnoc_axi_burst_state  state_q, state_d;
   tnoc_axi_beat_index   index_q, index_d;
   logic [AW-1:0]        address_q, address_d;
   logic [AW-1:0]        base_q;
   logic [AW-1:0]        span_q;
   logic [IW-1:0]        id_q;
   tnoc_axi_burst_length length_q;
   tnoc_axi_burst_size   size_q;
   tnoc_axi_burst_type   type_q;
   logic                 error_q;

   tnoc_axi_burst_size   cmd_size;
   tnoc_axi_burst_type   cmd_type;
   logic [7:0]           cmd_bytes;
   logic [AW-1:0]        cmd_span;
   logic                 cmd_error;
   logic                 command_accept;
   logic                 beat_accept;
   logic [AW-1:0]        next_address;

   // Illegal commands still run their full beat count, walking addresses as INCR.
   always_comb begin
      cmd_size  = tnoc_axi_burst_size'(i_burst_size);
      cmd_type  = tnoc_axi_burst_type'(i_burst_type);
      cmd_bytes = get_burst_size_in_bytes(cmd_size);
      cmd_span  = AW'(cmd_bytes) * AW'(unpack_burst_length(i_burst_length));
      cmd_error = (cmd_type == TNOC_AXI_RESERVED_BURST) ||
                  (cmd_type == TNOC_AXI_WRAPPING_BURST && !is_valid_wrap_length(i_burst_length)) ||
                  (int'(cmd_bytes) > DW / 8);
   end

   always_comb begin
      state_d         = state_q;
      index_d         = index_q;
      address_d       = address_q;
      o_beat_valid    = state_q == TNOC_AXI_BURST_ACTIVE;
      o_command_ready = state_q == TNOC_AXI_BURST_IDLE;
      o_beat_last     = o_beat_valid && index_q == length_q;
      beat_accept     = o_beat_valid && i_beat_ready;
`ifdef TNOC_AXI_BURST_ADDRESS_BACK_TO_BACK_EN
      if (beat_accept && o_beat_last) o_command_ready = 1'b1;
`endif
      command_accept  = i_command_valid && o_command_ready;
      if (beat_accept) begin
         index_d   = index_q + 8'd1;
         address_d = next_address;
         if (o_beat_last) state_d = TNOC_AXI_BURST_IDLE;
      end
      if (command_accept) begin
         state_d   = TNOC_AXI_BURST_ACTIVE;
         index_d   = '0;
         address_d = i_address;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= TNOC_AXI_BURST_IDLE;
         index_q   <= '0;
         address_q <= '0;
         base_q    <= '0;
         span_q    <= '0;
         id_q      <= '0;
         length_q  <= '0;
         size_q    <= TNOC_AXI_BURST_SIZE_1_BYTE;
         type_q    <= TNOC_AXI_FIXED_BURST;
         error_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         address_q <= address_d;
         if (command_accept) begin
            id_q     <= i_id;
            length_q <= i_burst_length;
            size_q   <= cmd_size;
            type_q   <= cmd_error ? TNOC_AXI_INCREMENTING_BURST : cmd_type;
            error_q  <= cmd_error;
            base_q   <= i_address & ~(cmd_span - AW'(1));
            span_q   <= cmd_span;
         end
      end
   end

   tnoc_axi_next_address_calc #(
      .AW (AW)
   ) u_next_address_calc (
      .i_burst_type   (type_q),
      .i_burst_size   (size_q),
      .i_address      (address_q),
      .i_base         (base_q),
      .i_span         (span_q),
      .o_next_address (next_address)
   );

   assign o_beat_id      = id_q;
   assign o_beat_address = address_q;
   assign o_beat_index   = index_q;
   assign o_beat_error   = error_q;

endmodule

// File: doc/tnoc_axi_burst_address_generator.md
Name: tnoc_axi_burst_address_generator

Overview:
Expands one accepted AXI AW/AR command into per-beat transfer addresses, in order, under a valid/ready handshake. It sits directly downstream of the AXI adapter's command capture, between the slave-side AXI address channel and the NoC request packer. It consumes the shared AXI burst length, size and type encodings and the length pack/unpack helpers.

Parameters:
AXI_CONFIG, TNOC_DEFAULT_AXI_CONFIG, tnoc_axi_config struct; id_width, address_width and data_width size the ports below.

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_command_valid  input  1  command present
o_command_ready  output  1  command accepted when high with valid
i_id  input  id_width  transaction ID
i_address  input  address_width  start address (may be unaligned)
i_burst_length  input  8  packed length (beats-1)
i_burst_size  input  3  tnoc_axi_burst_size
i_burst_type  input  2  tnoc_axi_burst_type (value 3 reserved)
o_beat_valid  output  1  beat present
i_beat_ready  input  1  beat consumed when high with valid
o_beat_id  output  id_width  ID of current burst
o_beat_address  output  address_width  address of current beat
o_beat_index  output  8  zero-based beat number
o_beat_last  output  1  final beat of burst
o_beat_error  output  1  illegal command flag, constant across the burst

Behaviour:
- Clock and reset: single clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset values: all outputs 0 except o_command_ready=1; state IDLE.
- FSM states: IDLE and BURST.
- IDLE:
  - o_command_ready=1 and o_beat_valid=0.
  - On valid&ready, register the command and go to BURST.
  - First beat is valid on the next cycle (1-cycle latency).
- BURST:
  - o_command_ready=0 and o_beat_valid=1.
  - Outputs hold stable while i_beat_ready=0.
  - Each beat handshake advances the index and address.
  - A handshake with o_beat_last=1 returns the FSM to IDLE.
- o_beat_last = (index == packed length). Beat count = unpack_burst_length(len), range 1..256.
- Beat 0 address is always i_address, unaligned address kept.
- Let bytes = 1<<size and aligned = address & ~(bytes-1).
- FIXED: every beat uses the start address.
- INCR:
  - next = aligned + bytes, modulo 2^address_width (wrap-around; no 4KB check).
- WRAP:
  - span = bytes*beats; base = address & ~(span-1).
  - next = aligned + bytes; if next == base+span then next = base.
- Error cases (o_beat_error=1 for the whole burst, addresses generated as INCR, beat count still honoured):
  - reserved burst type (3);
  - WRAP with beats not in {2,4,8,16};
  - bytes > data_width/8.
- Reset mid-burst: o_beat_valid drops immediately (async); the burst is discarded, no partial state is kept.

Optional Feature:
TNOC_AXI_BURST_ADDRESS_BACK_TO_BACK_EN.
- Defined: o_command_ready is also high in BURST during a cycle where o_beat_valid & i_beat_ready & o_beat_last. A command accepted in that cycle starts its beat 0 on the next cycle, giving zero bubble between bursts.
- Undefined: ready only in IDLE, giving one idle cycle between consecutive bursts.

Decomposition:
- Add to tnoc_axi_pkg:
  - typedef tnoc_axi_beat_index (logic [7:0]);
  - function get_burst_size_in_bytes(tnoc_axi_burst_size);
  - function is_valid_wrap_length(tnoc_axi_burst_length).
- One natural sub-module: tnoc_axi_next_address_calc, a combinational next-address calculator (type, size, base, span in; next address out). The FSM, counters and registers stay in the top.

Test Plan:
- INCR, addr 0x1003, size 4B, len 3 -> addresses 0x1003, 0x1004, 0x1008, 0x100C; last on index 3; error 0.
- WRAP, addr 0x0018, size 4B, len 7 -> addresses 0x18, 0x1C, 0x00, 0x04, 0x08, 0x0C, 0x10, 0x14; last on 0x14.
- FIXED, addr 0x40, size 8B, len 2, i_beat_ready held low 5 cycles on beat 1 -> 0x40 ×3; outputs stable while stalled; no beat lost or duplicated.
- WRAP with len 2 (3 beats) or burst type 3, addr 0x100, size 4B -> error=1 on all beats; addresses 0x100, 0x104, 0x108.
- INCR at addr 0xFFFF_FFFC (32-bit), size 4B, len 1 -> 0xFFFF_FFFC, then 0x0000_0000.
- Reset asserted on beat 2 of an 8-beat INCR -> valid=0 and ready=1 immediately. After release, a new command at 0x200 starts cleanly at index 0. With the _EN macro defined, back-to-back commands show no idle cycle.
